// File: rtl/board_drop_engine.sv
// Connect-4 board owner: lands a disc in the lowest free row of a column, then runs a
// fixed-length sequential probe around the new disc to detect a WIN_LEN run or a full board.
module board_drop_engine #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drop_req,
  input  logic [2:0] drop_col,
  input  logic [2:0] rd_col,
  input  logic [2:0] rd_row,
  output logic [1:0] rd_cell,
  output logic [1:0] game_status,
  output logic       invalid_column,
  output logic       player_turn,
  output logic       busy,
  output logic       done
);

  localparam int         CELLS    = COLS * ROWS;
  localparam logic [3:0] STEP_MAX = 4'(WIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, PLACE, CHECK, RESULT} state_t;

  state_t      state;
  // occupancy maps indexed {col,row} so any 3-bit coordinate pair is addressable
  logic [63:0] map1, map2;
  logic [3:0]  height [8];
  logic [6:0]  drops;
  logic [2:0]  cur_col, cur_row;
  logic        cur_player;

  logic [1:0]  dir;
  logic        back;
  logic [3:0]  step;
  logic        alive;
  logic [4:0]  run;
  logic        win;

  int          dc, dr, pc, pr;
  logic        inb, hit, last;
  logic [5:0]  pidx, ridx;
  logic [4:0]  run_nx;

  always_comb begin
    dc = 0;
    dr = 0;
    case (dir)
      2'd0:    dc = 1;
      2'd1:    dr = 1;
      2'd2:    begin dc = 1;  dr = 1; end
      default: begin dc = -1; dr = 1; end
    endcase
    if (back) begin
      dc = -dc;
      dr = -dr;
    end
    pc   = int'(cur_col) + dc * int'(step);
    pr   = int'(cur_row) + dr * int'(step);
    inb  = (pc >= 0) && (pc < COLS) && (pr >= 0) && (pr < ROWS);
    pidx = {pc[2:0], pr[2:0]};
    hit  = inb && (cur_player ? map2[pidx] : map1[pidx]);
    // a side stops contributing after its first miss
    run_nx = run + {4'd0, alive & hit};
    last   = (dir == 2'd3) && back && (step == STEP_MAX);
  end

  always_comb begin
    ridx    = {rd_col, rd_row};
    rd_cell = 2'b00;
    if (int'(rd_col) < COLS && int'(rd_row) < ROWS)
      rd_cell = {map2[ridx], map1[ridx]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      map1           <= '0;
      map2           <= '0;
      for (int i = 0; i < 8; i++) height[i] <= '0;
      drops          <= '0;
      cur_col        <= '0;
      cur_row        <= '0;
      cur_player     <= 1'b0;
      dir            <= '0;
      back           <= 1'b0;
      step           <= 4'd1;
      alive          <= 1'b1;
      run            <= 5'd1;
      win            <= 1'b0;
      game_status    <= 2'b00;
      invalid_column <= 1'b0;
      player_turn    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy spans the done cycle, so it drops one cycle after completion
          if (done)
            busy <= 1'b0;
          else if (drop_req && !busy && game_status == 2'b00) begin
            cur_col        <= drop_col;
            cur_player     <= player_turn;
            invalid_column <= 1'b0;
            busy           <= 1'b1;
            state          <= PLACE;
          end
        end
        PLACE: begin
          if (int'(cur_col) >= COLS || int'(height[cur_col]) == ROWS) begin
            invalid_column <= 1'b1;
            done           <= 1'b1;
            state          <= IDLE;
          end else begin
            if (cur_player) map2[{cur_col, height[cur_col][2:0]}] <= 1'b1;
            else            map1[{cur_col, height[cur_col][2:0]}] <= 1'b1;
            cur_row         <= height[cur_col][2:0];
            height[cur_col] <= height[cur_col] + 4'd1;
            drops           <= drops + 7'd1;
            dir             <= 2'd0;
            back            <= 1'b0;
            step            <= 4'd1;
            alive           <= 1'b1;
            run             <= 5'd1;
            win             <= 1'b0;
            state           <= CHECK;
          end
        end
        CHECK: begin
          win <= win | (int'(run_nx) >= WIN_LEN);
          if (step == STEP_MAX) begin
            step  <= 4'd1;
            alive <= 1'b1;
            back  <= ~back;
            if (back) begin
              dir <= dir + 2'd1;
              run <= 5'd1;
            end else begin
              run <= run_nx;
            end
            if (last) state <= RESULT;
          end else begin
            step  <= step + 4'd1;
            run   <= run_nx;
            alive <= alive & hit;
          end
        end
        RESULT: begin
          done  <= 1'b1;
          state <= IDLE;
          if (win)
            game_status <= 2'b01;
          else if (int'(drops) == CELLS)
            game_status <= 2'b10;
          else
            player_turn <= ~player_turn;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_drop_engine.sv
// Directed bench for board_drop_engine: timing, vertical/horizontal/diagonal wins,
// column-full and out-of-range rejects, tie and last-disc win, reset abort.
module tb_board_drop_engine;

  logic       clk, reset, drop_req;
  logic [2:0] drop_col, rd_col, rd_row;
  logic [1:0] rd_cell, game_status;
  logic       invalid_column, player_turn, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int seq[$];
  int lat, n0;

  board_drop_engine dut (
    .clk(clk), .reset(reset), .drop_req(drop_req), .drop_col(drop_col),
    .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell), .game_status(game_status),
    .invalid_column(invalid_column), .player_turn(player_turn), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_cell(input string tag, input int c, input int r, input int exp);
    rd_col = 3'(c);
    rd_row = 3'(r);
    #1;
    chk(tag, int'(rd_cell), exp);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    drop_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // lat = cycles from the first busy cycle to the done cycle; 60 means no done
  task automatic drop(input int c, output int l);
    drop_req = 1'b1;
    drop_col = 3'(c);
    @(negedge clk);
    drop_req = 1'b0;
    l = 0;
    while (!done && l < 60) begin
      @(negedge clk);
      l++;
    end
    @(negedge clk);
  endtask

  task automatic play(input string tag);
    int l;
    foreach (seq[i]) begin
      drop(seq[i], l);
      chk(tag, l, 26);
    end
  endtask

  initial begin
    reset = 1'b1; drop_req = 1'b0; drop_col = '0; rd_col = '0; rd_row = '0;
    do_reset();

    // reset state
    chk("rst_status", int'(game_status), 0);
    chk("rst_invalid", int'(invalid_column), 0);
    chk("rst_turn", int'(player_turn), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_cell("rst_cell", 3, 0, 0);

    // first drop timing, with a request while busy that must be ignored
    n0 = done_cnt;
    drop_req = 1'b1; drop_col = 3'd3;
    @(negedge clk);
    drop_req = 1'b0;
    chk("busy_accept", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    drop_req = 1'b1; drop_col = 3'd5;
    @(negedge clk);
    drop_req = 1'b0;
    lat = 3;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("first_lat", lat, 26);
    chk("busy_at_done", int'(busy), 1);
    @(negedge clk);
    chk("busy_after", int'(busy), 0);
    chk("done_once", done_cnt - n0, 1);
    chk_cell("first_cell", 3, 0, 1);
    chk_cell("ignored_cell", 5, 0, 0);
    chk("first_status", int'(game_status), 0);
    chk("first_turn", int'(player_turn), 1);

    // vertical P1 win in column 0, then a drop after game over
    do_reset();
    seq = '{0, 1, 0, 1, 0, 1, 0};
    play("vert_lat");
    chk("vert_status", int'(game_status), 1);
    chk("vert_turn", int'(player_turn), 0);
    chk_cell("vert_top", 0, 3, 1);
    chk_cell("vert_p2", 1, 2, 2);
    n0 = done_cnt;
    drop(4, lat);
    chk("over_no_done", done_cnt - n0, 0);
    chk_cell("over_cell", 4, 0, 0);
    chk("over_status", int'(game_status), 1);

    // full column and out-of-range column rejects
    do_reset();
    seq = '{2, 2, 2, 2, 2, 2};
    play("fill_lat");
    drop(2, lat);
    chk("full_lat", lat, 1);
    chk("full_invalid", int'(invalid_column), 1);
    chk("full_turn", int'(player_turn), 0);
    chk_cell("full_top", 2, 5, 2);
    drop(7, lat);
    chk("oor_lat", lat, 1);
    chk("oor_invalid", int'(invalid_column), 1);
    chk("oor_turn", int'(player_turn), 0);
    drop(3, lat);
    chk("valid_lat", lat, 26);
    chk("valid_invalid", int'(invalid_column), 0);
    chk("valid_turn", int'(player_turn), 1);
    chk_cell("rd_col7", 7, 0, 0);
    chk_cell("rd_row6", 0, 6, 0);

    // horizontal P1 win, last disc at col 2 inside cols 0..3
    do_reset();
    seq = '{0, 0, 1, 1, 3, 3, 2};
    play("horz_lat");
    chk("horz_status", int'(game_status), 1);
    chk("horz_turn", int'(player_turn), 0);

    // up-right diagonal P1 win, last disc at (1,1)
    do_reset();
    seq = '{0, 1, 2, 2, 2, 3, 3, 3, 3, 6, 1};
    play("diur_lat");
    chk("diur_status", int'(game_status), 1);
    chk("diur_turn", int'(player_turn), 0);

    // up-left diagonal P2 win, last disc at (2,1)
    do_reset();
    seq = '{0, 3, 0, 6, 0, 0, 1, 5, 1, 1, 2, 2};
    play("diul_lat");
    chk("diul_status", int'(game_status), 1);
    chk("diul_turn", int'(player_turn), 1);

    // full board with no run: tie
    do_reset();
    seq = '{0, 2, 2, 2, 2, 2, 2, 0, 0, 0, 0, 0, 1, 3, 3, 3, 3, 3, 3, 1, 1, 1, 1, 1,
            4, 6, 6, 6, 6, 6, 6, 4, 4, 4, 4, 4, 5, 5, 5, 5, 5};
    play("tie_lat");
    chk("tie_41_status", int'(game_status), 0);
    drop(5, lat);
    chk("tie_42_lat", lat, 26);
    chk("tie_status", int'(game_status), 2);
    chk("tie_turn", int'(player_turn), 1);

    // 42nd disc completes P2 row-5 run cols 3..6: win beats tie
    do_reset();
    seq = '{0, 3, 3, 0, 0, 3, 3, 0, 0, 3, 0, 3, 1, 6, 6, 1, 1, 6, 6, 1, 1, 6, 1, 6,
            4, 2, 2, 2, 2, 2, 2, 4, 4, 4, 4, 4, 5, 5, 5, 5, 5, 5};
    play("w42_lat");
    chk("w42_status", int'(game_status), 1);
    chk("w42_turn", int'(player_turn), 1);

    // reset during CHECK aborts the drop and clears everything
    do_reset();
    seq = '{0, 1};
    play("abort_lat");
    drop_req = 1'b1; drop_col = 3'd2;
    @(negedge clk);
    drop_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drop_req = 1'b1; drop_col = 3'd4;
    @(negedge clk);
    drop_req = 1'b0;
    repeat (7) @(negedge clk);
    n0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_status", int'(game_status), 0);
    chk("abort_turn", int'(player_turn), 0);
    chk_cell("abort_c0", 0, 0, 0);
    chk_cell("abort_c1", 1, 0, 0);
    chk_cell("abort_c2", 2, 0, 0);
    chk_cell("abort_c4", 4, 0, 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - n0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
